// File: rtl/relojes_pkg.sv
// Shared definitions for the parameterised clock generator:
// default parameter values and the FSM state encodings.
package relojes_pkg;

  localparam int unsigned N_CLK_DEF      = 3;
  localparam int unsigned BASE_SHIFT_DEF = 2;

  localparam logic [1:0] WARMUP = 2'd0;
  localparam logic [1:0] LOCKED = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

endpackage

// File: rtl/detector_flanco.sv
// Per-channel edge detector. Produces registered rise/fall strobes that
// land in the same cycle the derived clock bit changes.
//   clk32f   : fast reference clock
//   reset_L  : synchronous active-low reset
//   adv_i    : counter advances on this edge (strobes suppressed otherwise)
//   cur_i    : current value of the clock bit
//   nxt_i    : value the clock bit takes on this edge
//   rise_o   : 1 in the cycle the bit first reads 1
//   fall_o   : 1 in the cycle the bit first reads 0
module detector_flanco (
  input  logic clk32f,
  input  logic reset_L,
  input  logic adv_i,
  input  logic cur_i,
  input  logic nxt_i,
  output logic rise_o,
  output logic fall_o
);

  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Only a genuine count step can create an edge; forced clears cannot.
  always_comb begin
    rise_d = adv_i & ~cur_i & nxt_i;
    fall_d = adv_i & cur_i & ~nxt_i;
  end

  always_ff @(posedge clk32f) begin
    if (!reset_L) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/gen_relojes_param.sv
// Parameterised power-of-two clock divider with edge strobes and lock flag.
//   clk32f   : fast reference clock (all flops on rising edge)
//   reset_L  : synchronous active-low reset
//   enable   : 1 = run, 0 = freeze phase
//   sync_req : restart all phases from zero on the next edge
//   clk_out  : derived clocks, bit i has period 2^(BASE_SHIFT+1+i)
//   rise_stb : one-cycle pulse with each 0->1 of clk_out[i]
//   fall_stb : one-cycle pulse with each 1->0 of clk_out[i]
//   locked   : high once a full aligned period has completed
module gen_relojes_param
  import relojes_pkg::*;
#(
  parameter int unsigned N_CLK      = N_CLK_DEF,
  parameter int unsigned BASE_SHIFT = BASE_SHIFT_DEF
) (
  input  logic             clk32f,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             sync_req,
  output logic [N_CLK-1:0] clk_out,
  output logic [N_CLK-1:0] rise_stb,
  output logic [N_CLK-1:0] fall_stb,
  output logic             locked
);

  localparam int unsigned W = BASE_SHIFT + N_CLK;

  logic [W-1:0] cnt_q, cnt_d;
  logic [1:0]   state_q, state_d;
  logic         resume_q, resume_d;  // 1 = return to LOCKED after HOLD
  logic         locked_q, locked_d;
  logic         adv_c;
  logic [1:0]   eff_state_c;

  // Next-state logic: sync beats enable; a resume counts on the same edge.
  always_comb begin
    cnt_d       = cnt_q;
    state_d     = state_q;
    resume_d    = resume_q;
    locked_d    = locked_q;
    adv_c       = 1'b0;
    eff_state_c = (state_q == LOCKED || (state_q == HOLD && resume_q)) ? LOCKED : WARMUP;

    if (sync_req) begin
      cnt_d    = '0;
      state_d  = WARMUP;
      resume_d = 1'b0;
      locked_d = 1'b0;
    end else if (!enable) begin
      state_d  = HOLD;
      resume_d = (eff_state_c == LOCKED);
    end else begin
      adv_c   = 1'b1;
      cnt_d   = cnt_q + W'(1);
      state_d = eff_state_c;
      // Wrap to zero closes the first full period of the slowest clock.
      if (eff_state_c == WARMUP && cnt_q == '1) begin
        state_d  = LOCKED;
        locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk32f) begin
    if (!reset_L) begin
      cnt_q    <= '0;
      state_q  <= WARMUP;
      resume_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      resume_q <= resume_d;
      locked_q <= locked_d;
    end
  end

  // Clock outputs are the counter flops themselves.
  assign clk_out = cnt_q[W-1:BASE_SHIFT];
  assign locked  = locked_q;

  for (genvar gi = 0; gi < N_CLK; gi++) begin : g_det
    detector_flanco u_det (
      .clk32f  (clk32f),
      .reset_L (reset_L),
      .adv_i   (adv_c),
      .cur_i   (cnt_q[BASE_SHIFT+gi]),
      .nxt_i   (cnt_d[BASE_SHIFT+gi]),
      .rise_o  (rise_stb[gi]),
      .fall_o  (fall_stb[gi])
    );
  end

endmodule

// File: tb/tb_gen_relojes_param.sv
module tb_gen_relojes_param;

  logic       clk32f = 1'b0;
  logic       reset_L = 1'b0;
  logic       enable = 1'b0;
  logic       sync_req = 1'b0;

  logic [2:0] clk0, rise0, fall0;
  logic       lock0;
  logic [3:0] clk1, rise1, fall1;
  logic       lock1;

  always #5 clk32f = ~clk32f;

  // Default build: clk4f/clk2f/clk
  gen_relojes_param dut0 (
    .clk32f   (clk32f),
    .reset_L  (reset_L),
    .enable   (enable),
    .sync_req (sync_req),
    .clk_out  (clk0),
    .rise_stb (rise0),
    .fall_stb (fall0),
    .locked   (lock0)
  );

  // Fastest build: N_CLK=4, BASE_SHIFT=0
  gen_relojes_param #(.N_CLK(4), .BASE_SHIFT(0)) dut1 (
    .clk32f   (clk32f),
    .reset_L  (reset_L),
    .enable   (enable),
    .sync_req (sync_req),
    .clk_out  (clk1),
    .rise_stb (rise1),
    .fall_stb (fall1),
    .locked   (lock1)
  );

  typedef struct {
    logic [2:0] c0, r0, f0;
    logic       l0;
    logic [3:0] c1, r1, f1;
    logic       l1;
    bit         tally;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   tally0 = 0;
  int   tally1[4] = '{0, 0, 0, 0};
  longint k = 0;  // enabled counts since last reset/sync

  function automatic logic bitk(input longint v, input int b);
    return ((v >> b) & 64'd1) != 64'd0;
  endfunction

  // Reference: clocks are bits of an ideal counter, strobes are bit changes
  // across a counting step, lock means one full counter period elapsed.
  function automatic exp_t build(input longint kk, input bit counted, input bit t);
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e.c0[i] = bitk(kk, 2 + i);
      e.r0[i] = counted && bitk(kk, 2 + i) && !bitk(kk - 1, 2 + i);
      e.f0[i] = counted && !bitk(kk, 2 + i) && bitk(kk - 1, 2 + i);
    end
    for (int i = 0; i < 4; i++) begin
      e.c1[i] = bitk(kk, i);
      e.r1[i] = counted && bitk(kk, i) && !bitk(kk - 1, i);
      e.f1[i] = counted && !bitk(kk, i) && bitk(kk - 1, i);
    end
    e.l0 = (kk >= 32);
    e.l1 = (kk >= 16);
    e.tally = t;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clk32f cycle of stimulus; expected post-edge values go to the scoreboard.
  task automatic step(input bit r, input bit en, input bit s, input bit t);
    bit counted;
    @(negedge clk32f);
    reset_L  = r;
    enable   = en;
    sync_req = s;
    counted  = 1'b0;
    if (!r || s) k = 0;
    else if (en) begin
      k++;
      counted = 1'b1;
    end
    sbq.push_back(build(k, counted, t));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 10) begin
      @(negedge clk32f);
      n++;
    end
    checks++;
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    #2;
  endtask

  // Monitor: compares every cycle's outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk32f);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("clk_out0",  8'(clk0),  8'(e.c0));
        chk("rise_stb0", 8'(rise0), 8'(e.r0));
        chk("fall_stb0", 8'(fall0), 8'(e.f0));
        chk("locked0",   8'(lock0), 8'(e.l0));
        chk("clk_out1",  8'(clk1),  8'(e.c1));
        chk("rise_stb1", 8'(rise1), 8'(e.r1));
        chk("fall_stb1", 8'(fall1), 8'(e.f1));
        chk("locked1",   8'(lock1), 8'(e.l1));
        if (e.tally) begin
          tally0 += int'(rise0[2]);
          for (int i = 0; i < 4; i++) tally1[i] += int'(rise1[i]);
        end
      end
    end
  end

  initial begin
    bit r, en, s;

    // Reset state
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);

    // 64 enabled cycles from reset; tally rise strobes
    for (int j = 0; j < 64; j++) step(1'b1, 1'b1, 1'b0, 1'b1);
    drain();
    chk("rise2_count_def", 8'(tally0), 8'd2);
    for (int i = 0; i < 4; i++) chk("rise_count_fast", 8'(tally1[i]), 8'(64 >> (i + 1)));

    // Freeze at count 13 for 10 cycles, then resume
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 13; j++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++)  step(1'b1, 1'b1, 1'b0, 1'b0);

    // Run into LOCKED, sync at count 21, then relock
    while (!(k >= 32 && (k % 32) == 21)) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 40; j++) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Held sync, then counting resumes after release
    for (int j = 0; j < 4; j++) step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 6; j++) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Reset together with sync at count 9
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 9; j++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Randomised traffic; sync is quiet in alternate windows to allow locking
    for (int j = 0; j < 1600; j++) begin
      r  = ($urandom_range(0, 99) >= 2);
      en = ($urandom_range(0, 99) < 80);
      s  = ((j % 400) < 200) ? ($urandom_range(0, 99) < 4) : 1'b0;
      step(r, en, s, 1'b0);
    end

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
